dct_block_sequencer: RTL and testbench
======================================

Name: dct_block_sequencer

Overview:
- Front-end controller for the dct_idct core, which consumes one 8-bit pixel per CLK with no stall capability and frames blocks on a free-running 64-cycle slot aligned to reset.
- Accepts a backpressured pixel stream, buffers whole 8x8 blocks in a ping-pong store, and launches each block into the core only on a slot boundary.
- Tags the core's 12-bit dct_2d output stream with valid, start-of-block, end-of-block and coefficient index.

Parameters:
- DATA_W, 8, pixel width (core xin width)
- OUT_W, 12, coefficient width (core dct_2d width)
- BLK_LEN, 64, samples per block; must be a power of 2
- CORE_LATENCY, 92, cycles from the core accepting sample 0 to dct_2d carrying coefficient 0

Ports:
- CLK  in  1  system clock; all logic is on the rising edge
- RST  in  1  synchronous, active-high reset; also drives the core RST
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  sequencer can accept a pixel
- in_data  in  DATA_W  pixel, raster order within the block
- core_xin  out  DATA_W  to core xin
- core_dout  in  OUT_W  from core dct_2d
- out_valid  out  1  out_data is a real coefficient
- out_sob  out  1  first coefficient of a block
- out_eob  out  1  last coefficient of a block
- out_idx  out  6  coefficient index 0..63
- out_data  out  OUT_W  registered core_dout
- busy  out  1  any bank full or any tag in flight
- blk_cnt  out  16  blocks emitted; wraps at 65535->0

Behaviour:
- Reset values: in_ready=1, core_xin=0, out_valid=0, out_sob=0, out_eob=0, out_idx=0, out_data=0, busy=0, blk_cnt=0.
- Reset also clears slot_cnt, both bank full flags, wr_bank, rd_bank, wr_ptr and the tag delay line.
- Reset mid-operation discards buffered and in-flight blocks; outputs return to reset values on the cycle after RST is sampled high.
- slot_cnt (6-bit) is 0 in the first cycle after RST deasserts and increments every cycle, wrapping 63->0. A slot is the window slot_cnt=0..63.
- Write side:
  - in_ready = ~full[wr_bank].
  - Each handshake (in_valid & in_ready) writes mem[wr_bank][wr_ptr] and increments wr_ptr.
  - A handshake at wr_ptr=63 sets full[wr_bank], toggles wr_bank and wraps wr_ptr to 0.
  - Upstream gaps are allowed anywhere in a block.
- Launch: if full[rd_bank] holds at the cycle where slot_cnt=63, the next slot is a launch slot.
  - During a launch slot, core_xin = mem[rd_bank][slot_cnt] in the cycle with that slot_cnt value; the memory read is prefetched so core_xin is a register output.
  - In the final cycle of the slot (slot_cnt=63), full[rd_bank] clears and rd_bank toggles.
- Idle slot: core_xin=0 for all 64 cycles.
- A bank that fills mid-slot waits for the next boundary. There is no partial launch.
- Simultaneous events: a bank fill on the write side and a bank free on the read side in the same cycle are both applied. A write into a bank being freed that cycle is impossible, because in_ready was 0 for it.
- Output tagging:
  - A 1-bit launch pulse (high at slot_cnt=0 of a launch slot) enters a CORE_LATENCY-deep shift register.
  - Its emergence starts a 64-cycle tag run. out_data/out_valid are registered, so out_valid first rises CORE_LATENCY+1 cycles after launch sample 0 enters the core.
  - During a run, out_idx counts 0..63, out_sob=1 at idx 0, and out_eob=1 at idx 63.
  - blk_cnt increments on the cycle out_eob is asserted.
  - Back-to-back launch slots produce a contiguous 128-cycle out_valid run.
- Outputs have no backpressure; downstream must accept every valid cycle.
- Throughput: one block per 64 cycles sustained. Two banks allow one block filling while one is launching.

Decomposition:
- Package dct_seq_pkg holds BLK_LEN, the log2 index width, the CORE_LATENCY default and a bank_idx_t typedef.
- One sub-module, dct_pingpong_buf: a 2x64xDATA_W store with a write port (bank, ptr, data, we), a prefetched read port (bank, addr), and the full flags with set/clear logic.
- Slot counter, launch decision and the tag delay line stay in dct_block_sequencer.

Test Plan:
- Reset release, no input for 200 cycles -> core_xin=0 throughout, out_valid=0, busy=0, blk_cnt=0.
- Block 0x28,0x21,0x21,0x16,... (64 pixels) streamed continuously from slot_cnt=0:
  - in_ready stays 1.
  - The block launches on the next boundary (cycle 64), with core_xin=0x28 at cycle 64.
  - out_sob rises at cycle 64+92+1=157; out_eob at 220; blk_cnt=1.
- Four identical blocks streamed with no gaps:
  - in_ready drops to 0 when both banks are full.
  - Launches occur in consecutive slots.
  - out_valid stays high for 256 contiguous cycles; out_idx follows 0..63 four times; blk_cnt=4.
- Upstream gaps (in_valid toggling 1-of-3 cycles) -> the block completes at pixel 64 and launches at the next boundary only; core_xin is never a partial block; coefficients match the gap-free run.
- Bank completes at slot_cnt=63 exactly -> launches in the immediately following slot. Bank completes at slot_cnt=0 -> waits 63 cycles.
- RST pulsed for 1 cycle at cycle 180 during a launch and out_valid run -> next cycle out_valid=0, in_ready=1, blk_cnt=0. No tagged output appears for the aborted blocks.

Source files
------------

// File: rtl/dct_seq_pkg.sv
// Shared constants and types for the dct_idct front-end sequencer.
package dct_seq_pkg;

    localparam int BLK_LEN_DEF      = 64;                  // samples per 8x8 block
    localparam int BLK_IDX_W        = $clog2(BLK_LEN_DEF); // index / slot counter width
    localparam int CORE_LATENCY_DEF = 92;                  // core sample-0 in to coeff-0 out

    // Selects one of the two ping-pong banks.
    typedef logic bank_idx_t;

    // What the current 64-cycle slot is doing on the core input.
    typedef enum logic [0:0] {
        SLOT_IDLE   = 1'b0,
        SLOT_LAUNCH = 1'b1
    } slot_mode_t;

endpackage

// File: rtl/dct_pingpong_buf.sv
// Two-bank block store: one bank fills from upstream while the other is read
// out toward the core. The read port is registered so its output can drive
// the core input directly. Fill flags live here with their set/clear logic.
module dct_pingpong_buf
    import dct_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BLK_LEN = BLK_LEN_DEF,
    parameter int AW      = $clog2(BLK_LEN)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  bank_idx_t         wr_bank,
    input  logic [AW-1:0]     wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  bank_idx_t         rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr,
    input  bank_idx_t         clr_bank,
    output logic [1:0]        full_nxt
);

    localparam logic [AW-1:0] LAST_PTR = AW'(BLK_LEN - 1);

    logic [DATA_W-1:0] mem_r [2*BLK_LEN];
    logic [DATA_W-1:0] rd_data_r;
    logic [1:0]        full_r;
    logic [1:0]        full_nxt_s;
    logic              set_s;

    // Flag update: a bank is freed when its launch ends and marked full on its last write
    always_comb begin
        full_nxt_s = full_r;
        set_s      = we & (wr_ptr == LAST_PTR);
        if (clr) begin
            full_nxt_s[clr_bank] = 1'b0;
        end else begin
            full_nxt_s[clr_bank] = full_r[clr_bank];
        end
        if (set_s) begin
            full_nxt_s[wr_bank] = 1'b1;
        end else begin
            full_nxt_s[wr_bank] = full_nxt_s[wr_bank];
        end
    end

    // Sample storage; contents are only meaningful while the owning bank is full
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[{wr_bank, wr_ptr}] <= wr_data;
        end
    end

    // Prefetched read (zero when not reading) and fill-flag register
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_r <= DATA_W'(0);
            full_r    <= 2'b00;
        end else begin
            rd_data_r <= rd_en ? mem_r[{rd_bank, rd_addr}] : DATA_W'(0);
            full_r    <= full_nxt_s;
        end
    end

    assign rd_data  = rd_data_r;
    assign full_nxt = full_nxt_s;

endmodule

// File: rtl/dct_block_sequencer.sv
// Front-end for the dct_idct core: buffers whole blocks from a backpressured
// pixel stream, launches them on the core's free-running 64-cycle slot, and
// tags the delayed coefficient stream with valid/sob/eob/index.
module dct_block_sequencer
    import dct_seq_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int OUT_W        = 12,
    parameter int BLK_LEN      = BLK_LEN_DEF,
    parameter int CORE_LATENCY = CORE_LATENCY_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [DATA_W-1:0]          core_xin,
    input  logic [OUT_W-1:0]           core_dout,
    output logic                       out_valid,
    output logic                       out_sob,
    output logic                       out_eob,
    output logic [$clog2(BLK_LEN)-1:0] out_idx,
    output logic [OUT_W-1:0]           out_data,
    output logic                       busy,
    output logic [15:0]                blk_cnt
);

    localparam int              IDX_W    = $clog2(BLK_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_LEN - 1);

    // Slot / write / read state
    logic [IDX_W-1:0]  slot_cnt_r;
    slot_mode_t        mode_r, mode_nxt_s;
    bank_idx_t         wr_bank_r, wr_bank_nxt_s;
    bank_idx_t         rd_bank_r, rd_bank_nxt_s;
    logic [IDX_W-1:0]  wr_ptr_r, wr_ptr_nxt_s;
    logic              wr_fire_s, slot_end_s, clr_s, rd_en_s;
    logic [IDX_W-1:0]  rd_addr_s;
    logic [1:0]        full_nxt_s;

    // Tag path state
    logic [CORE_LATENCY-1:0] shift_r, shift_nxt_s;
    logic              launch_pulse_s, emerge_s;
    logic              run_act_r, run_act_nxt_s;
    logic [IDX_W-1:0]  run_idx_r, run_idx_nxt_s;
    logic              tag_valid_s, tag_sob_s, tag_eob_s;
    logic [IDX_W-1:0]  tag_idx_s;

    // Registered outputs
    logic              in_ready_r, in_ready_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              out_valid_r, out_sob_r, out_eob_r;
    logic [IDX_W-1:0]  out_idx_r;
    logic [OUT_W-1:0]  out_data_r;
    logic [15:0]       blk_cnt_r, blk_cnt_nxt_s;

    dct_pingpong_buf #(
        .DATA_W  (DATA_W),
        .BLK_LEN (BLK_LEN),
        .AW      (IDX_W)
    ) u_buf (
        .CLK      (CLK),
        .RST      (RST),
        .we       (wr_fire_s),
        .wr_bank  (wr_bank_r),
        .wr_ptr   (wr_ptr_r),
        .wr_data  (in_data),
        .rd_en    (rd_en_s),
        .rd_bank  (rd_bank_nxt_s),
        .rd_addr  (rd_addr_s),
        .rd_data  (core_xin),
        .clr      (clr_s),
        .clr_bank (rd_bank_r),
        .full_nxt (full_nxt_s)
    );

    // Write-side pointer/bank advance and end-of-launch bank release
    always_comb begin
        wr_fire_s     = in_valid & in_ready_r;
        slot_end_s    = (slot_cnt_r == LAST_IDX);
        clr_s         = (mode_r == SLOT_LAUNCH) & slot_end_s;
        wr_ptr_nxt_s  = wr_ptr_r;
        wr_bank_nxt_s = wr_bank_r;
        rd_bank_nxt_s = rd_bank_r;
        if (wr_fire_s) begin
            wr_ptr_nxt_s = wr_ptr_r + IDX_W'(1);
            if (wr_ptr_r == LAST_IDX) begin
                wr_bank_nxt_s = ~wr_bank_r;
            end else begin
                wr_bank_nxt_s = wr_bank_r;
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (clr_s) begin
            rd_bank_nxt_s = ~rd_bank_r;
        end else begin
            rd_bank_nxt_s = rd_bank_r;
        end
    end

    // Slot FSM: decide at each slot boundary whether the next slot launches.
    // The decision sees a bank that fills in the boundary cycle itself.
    always_comb begin
        mode_nxt_s = mode_r;
        rd_addr_s  = slot_cnt_r + IDX_W'(1);
        case (mode_r)
            SLOT_IDLE: begin
                if (slot_end_s) begin
                    mode_nxt_s = full_nxt_s[rd_bank_nxt_s] ? SLOT_LAUNCH : SLOT_IDLE;
                end else begin
                    mode_nxt_s = SLOT_IDLE;
                end
            end
            SLOT_LAUNCH: begin
                if (slot_end_s) begin
                    mode_nxt_s = full_nxt_s[rd_bank_nxt_s] ? SLOT_LAUNCH : SLOT_IDLE;
                end else begin
                    mode_nxt_s = SLOT_LAUNCH;
                end
            end
            default: begin
                mode_nxt_s = SLOT_IDLE;
            end
        endcase
        // Read one cycle ahead so core_xin holds sample N while slot_cnt is N
        rd_en_s = (mode_nxt_s == SLOT_LAUNCH);
    end

    // Tag path: delay the launch pulse by the core latency, then run a 64-sample index
    always_comb begin
        launch_pulse_s = (mode_r == SLOT_LAUNCH) & (slot_cnt_r == IDX_W'(0));
        shift_nxt_s    = {shift_r[CORE_LATENCY-2:0], launch_pulse_s};
        emerge_s       = shift_r[CORE_LATENCY-1];
        tag_valid_s    = 1'b0;
        tag_idx_s      = IDX_W'(0);
        run_act_nxt_s  = run_act_r;
        run_idx_nxt_s  = run_idx_r;
        if (emerge_s) begin
            tag_valid_s   = 1'b1;
            tag_idx_s     = IDX_W'(0);
            run_act_nxt_s = 1'b1;
            run_idx_nxt_s = IDX_W'(1);
        end else if (run_act_r) begin
            tag_valid_s   = 1'b1;
            tag_idx_s     = run_idx_r;
            run_idx_nxt_s = run_idx_r + IDX_W'(1);
            run_act_nxt_s = (run_idx_r != LAST_IDX);
        end else begin
            run_act_nxt_s = 1'b0;
            run_idx_nxt_s = run_idx_r;
        end
        tag_sob_s     = tag_valid_s & (tag_idx_s == IDX_W'(0));
        tag_eob_s     = tag_valid_s & (tag_idx_s == LAST_IDX);
        blk_cnt_nxt_s = tag_eob_s ? (blk_cnt_r + 16'd1) : blk_cnt_r;
    end

    // Status outputs computed from next-state so the registers are exact, not lagging
    always_comb begin
        in_ready_nxt_s = ~full_nxt_s[wr_bank_nxt_s];
        busy_nxt_s     = (|full_nxt_s) | (mode_nxt_s == SLOT_LAUNCH) | (|shift_nxt_s)
                       | run_act_nxt_s | tag_valid_s;
    end

    // Slot counter, FSM and write/read bank state
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt_r <= IDX_W'(0);
            mode_r     <= SLOT_IDLE;
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            wr_ptr_r   <= IDX_W'(0);
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            slot_cnt_r <= slot_cnt_r + IDX_W'(1);
            mode_r     <= mode_nxt_s;
            wr_bank_r  <= wr_bank_nxt_s;
            rd_bank_r  <= rd_bank_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            in_ready_r <= in_ready_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    // Tag delay line, index run and registered output stream
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_r     <= {CORE_LATENCY{1'b0}};
            run_act_r   <= 1'b0;
            run_idx_r   <= IDX_W'(0);
            out_valid_r <= 1'b0;
            out_sob_r   <= 1'b0;
            out_eob_r   <= 1'b0;
            out_idx_r   <= IDX_W'(0);
            out_data_r  <= OUT_W'(0);
            blk_cnt_r   <= 16'd0;
        end else begin
            shift_r     <= shift_nxt_s;
            run_act_r   <= run_act_nxt_s;
            run_idx_r   <= run_idx_nxt_s;
            out_valid_r <= tag_valid_s;
            out_sob_r   <= tag_sob_s;
            out_eob_r   <= tag_eob_s;
            out_idx_r   <= tag_idx_s;
            out_data_r  <= core_dout;
            blk_cnt_r   <= blk_cnt_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_sob   = out_sob_r;
    assign out_eob   = out_eob_r;
    assign out_idx   = out_idx_r;
    assign out_data  = out_data_r;
    assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer. A stand-in core delays core_xin by
// 92 cycles and maps each pixel x to the 12-bit value {x[3:0], x}.
module tb_dct_block_sequencer;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  core_xin;
    logic [11:0] core_dout;
    logic        out_valid;
    logic        out_sob;
    logic        out_eob;
    logic [5:0]  out_idx;
    logic [11:0] out_data;
    logic        busy;
    logic [15:0] blk_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] pipe [92];

    dct_block_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_xin  (core_xin),
        .core_dout (core_dout),
        .out_valid (out_valid),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] pix(input int i);
        logic [7:0] v;
        case (i)
            0:       v = 8'h28;
            1:       v = 8'h21;
            2:       v = 8'h21;
            3:       v = 8'h16;
            default: v = 8'((i * 37 + 11) % 256);
        endcase
        return v;
    endfunction

    function automatic logic [11:0] coef(input logic [7:0] x);
        return {x[3:0], x};
    endfunction

    // Stand-in core: dct_2d at cycle c reflects xin from cycle c-92
    always @(posedge CLK) begin
        pipe[0] <= core_xin;
        for (int k = 1; k < 92; k++) pipe[k] <= pipe[k-1];
    end
    assign core_dout = coef(pipe[91]);

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"},  int'(in_ready),  1);
        check({tag, " core_xin"},  int'(core_xin),  0);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " out_sob"},   int'(out_sob),   0);
        check({tag, " out_eob"},   int'(out_eob),   0);
        check({tag, " out_idx"},   int'(out_idx),   0);
        check({tag, " out_data"},  int'(out_data),  0);
        check({tag, " busy"},      int'(busy),      0);
        check({tag, " blk_cnt"},   int'(blk_cnt),   0);
    endtask

    // Leaves the bench at the falling edge of cycle 0 (slot_cnt = 0)
    task automatic do_reset(input int id);
        @(negedge CLK);
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge CLK);
        check_reset_vals($sformatf("rst%0d", id));
        RST = 1'b0;
    endtask

    typedef struct {
        int start;      // first cycle a pixel is offered
        int gap;        // offer one pixel every 'gap' cycles
        int nblk;       // blocks to send
        int run;        // cycles to observe
        int exp_launch; // first cycle core_xin is non-zero (-1: never)
        int exp_sob;    // first out_sob cycle
        int exp_eob;    // last out_eob cycle
        int exp_stall;  // first cycle an offered pixel sees in_ready=0
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    int sent, total, launch, sob, eob, stall, vcnt, runs, beat, b, nz;
    bit pending, prev_v, busy_seen, offer;
    logic [19:0] exp_beat, act_beat;

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        //            start gap nblk run  launch sob  eob  stall
        vecs[0] = '{  0,   1,  0,   200,  -1,    -1,  -1,  -1 };  // idle
        vecs[1] = '{  0,   1,  1,   300,  64,    157, 220, -1 };  // fills at slot 63
        vecs[2] = '{  1,   1,  1,   360,  128,   221, 284, -1 };  // fills at slot 0, waits
        vecs[3] = '{  64,  1,  1,   360,  128,   221, 284, -1 };  // fills at 2nd slot 63
        vecs[4] = '{  0,   3,  1,   420,  192,   285, 348, -1 };  // 1-of-3 gaps
        vecs[5] = '{  1,   1,  4,   520,  128,   221, 476, 129 }; // both banks fill, stall

        for (int i = 0; i < NV; i++) begin
            do_reset(i);
            sent = 0; pending = 1'b0; launch = -1; sob = -1; eob = -1; stall = -1;
            vcnt = 0; runs = 0; beat = 0; prev_v = 1'b0; busy_seen = 1'b0;
            total = vecs[i].nblk * 64;
            for (int t = 0; t < vecs[i].run; t++) begin
                if (core_xin != 8'h00 && launch < 0) launch = t;
                if (busy) busy_seen = 1'b1;
                if (out_valid) begin
                    vcnt++;
                    if (!prev_v) runs++;
                    if (out_sob && sob < 0) sob = t;
                    if (out_eob) eob = t;
                    b        = beat % 64;
                    exp_beat = {6'(b), (b == 0), (b == 63), coef(pix(b))};
                    act_beat = {out_idx, out_sob, out_eob, out_data};
                    check($sformatf("row%0d beat%0d", i, beat), int'(act_beat), int'(exp_beat));
                    beat++;
                end
                prev_v = out_valid;
                offer  = 1'b0;
                if (sent < total && t >= vecs[i].start)
                    offer = (vecs[i].gap == 1) || pending || (((t - vecs[i].start) % vecs[i].gap) == 0);
                in_valid = offer;
                in_data  = pix(sent % 64);
                if (offer && !in_ready && stall < 0) stall = t;
                if (offer && in_ready) sent++;
                pending = offer && !in_ready;
                @(negedge CLK);
            end
            in_valid = 1'b0;
            check($sformatf("row%0d launch_cycle", i), launch, vecs[i].exp_launch);
            check($sformatf("row%0d sob_cycle", i),    sob,    vecs[i].exp_sob);
            check($sformatf("row%0d eob_cycle", i),    eob,    vecs[i].exp_eob);
            check($sformatf("row%0d stall_cycle", i),  stall,  vecs[i].exp_stall);
            check($sformatf("row%0d valid_count", i),  vcnt,   64 * vecs[i].nblk);
            check($sformatf("row%0d valid_runs", i),   runs,   (vecs[i].nblk > 0) ? 1 : 0);
            check($sformatf("row%0d blk_cnt", i),      int'(blk_cnt), vecs[i].nblk);
            check($sformatf("row%0d busy_seen", i),    int'(busy_seen), (vecs[i].nblk > 0) ? 1 : 0);
            check($sformatf("row%0d busy_end", i),     int'(busy), 0);
            check($sformatf("row%0d in_ready_end", i), int'(in_ready), 1);
            check($sformatf("row%0d accepted", i),     sent, total);
        end

        // Reset pulse in the middle of a launch and an output run
        do_reset(90);
        for (int t = 0; t < 180; t++) begin
            in_valid = 1'b1;
            in_data  = pix(t % 64);
            @(negedge CLK);
        end
        check("midrst valid_before", int'(out_valid), 1);
        check("midrst xin_before_nz", int'(core_xin != 8'h00), 1);
        RST      = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        check_reset_vals("midrst");
        RST = 1'b0;
        vcnt = 0;
        nz   = 0;
        for (int t = 0; t < 300; t++) begin
            if (out_valid) vcnt++;
            if (core_xin != 8'h00) nz++;
            @(negedge CLK);
        end
        check("midrst valid_after", vcnt, 0);
        check("midrst xin_after", nz, 0);
        check("midrst blk_cnt_after", int'(blk_cnt), 0);
        check("midrst busy_after", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
